// File: rtl/vector_elem_sequencer.sv
// Element-serial vector sequencer: issues one element pair per cycle to an external
// lane, collects the lane results in order and returns the assembled vector with its tag.
module vector_elem_sequencer #(
   parameter int  ELEN = 32,
   parameter int  VLEN = 256,
   localparam int NE   = VLEN / ELEN,
   localparam int IW   = $clog2(NE),
   localparam int VLW  = IW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [VLW-1:0]    req_vl,
   input  logic [VLEN-1:0]   req_vs1,
   input  logic [VLEN-1:0]   req_vs2,
   input  logic [5:0]        req_tag,
   output logic [ELEN-1:0]   lane_op1,
   output logic [ELEN-1:0]   lane_op2,
   output logic [3:0]        lane_vec_op,
   output logic              lane_valid,
   input  logic [ELEN-1:0]   lane_result,
   input  logic              lane_valid_out,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [VLEN-1:0]   resp_data,
   output logic [5:0]        resp_tag,
   input  logic              flush
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

   localparam logic [VLW-1:0] NE_V = VLW'(NE);
   localparam logic [VLW-1:0] ONE  = VLW'(1);

   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [5:0]        tag_q, tag_d;
   logic [VLEN-1:0]   vs1_q, vs1_d;
   logic [VLEN-1:0]   vs2_q, vs2_d;
   logic [VLEN-1:0]   res_q, res_d;
   logic [VLW-1:0]    vl_q, vl_d;
   logic [VLW-1:0]    issue_idx_q, issue_idx_d;
   logic [VLW-1:0]    collect_idx_q, collect_idx_d;
   logic              lane_valid_q, lane_valid_d;
   logic [ELEN-1:0]   lane_op1_q, lane_op1_d;
   logic [ELEN-1:0]   lane_op2_q, lane_op2_d;
   logic [3:0]        lane_vec_op_q, lane_vec_op_d;
   logic              resp_valid_q, resp_valid_d;

   logic [VLW-1:0]    vl_clamp;
   logic              accept;
   logic              capture;
   logic [ELEN-1:0]   vs1_elem [NE];
   logic [ELEN-1:0]   vs2_elem [NE];

   assign req_ready = (state_q == IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign vl_clamp  = (req_vl > NE_V) ? NE_V : req_vl;
   assign capture   = lane_valid_out && ((state_q == ISSUE) || (state_q == DRAIN))
                      && (collect_idx_q < vl_q);

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      tag_d         = tag_q;
      vs1_d         = vs1_q;
      vs2_d         = vs2_q;
      res_d         = res_q;
      vl_d          = vl_q;
      issue_idx_d   = issue_idx_q;
      collect_idx_d = collect_idx_q;

      if (capture) begin
         res_d[int'(collect_idx_q[IW-1:0]) * ELEN +: ELEN] = lane_result;
         collect_idx_d = collect_idx_q + ONE;
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d          = req_op;
               tag_d         = req_tag;
               vs1_d         = req_vs1;
               vs2_d         = req_vs2;
               vl_d          = vl_clamp;
               issue_idx_d   = '0;
               collect_idx_d = '0;
               res_d         = '0;
               state_d       = (vl_clamp == '0) ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            issue_idx_d = issue_idx_q + ONE;
            if (issue_idx_q == vl_q - ONE) state_d = DRAIN;
         end
         DRAIN: begin
            if (capture && (collect_idx_q == vl_q - ONE)) state_d = RESP;
         end
         RESP: begin
            if (resp_valid_q && resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) state_d = IDLE;

      // An empty vector waits one cycle in RESP before presenting, so latency stays vl+1.
      resp_valid_d = (state_d == RESP) && (state_q != IDLE);
   end

   for (genvar gi = 0; gi < NE; gi++) begin : g_unpack
      assign vs1_elem[gi] = vs1_d[gi*ELEN +: ELEN];
      assign vs2_elem[gi] = vs2_d[gi*ELEN +: ELEN];
   end

   // Lane outputs are registered from next-state so they line up with the ISSUE cycles.
   always_comb begin
      lane_valid_d  = 1'b0;
      lane_op1_d    = '0;
      lane_op2_d    = '0;
      lane_vec_op_d = '0;
      if (state_d == ISSUE) begin
         lane_valid_d  = 1'b1;
         lane_op1_d    = vs1_elem[issue_idx_d[IW-1:0]];
         lane_op2_d    = vs2_elem[issue_idx_d[IW-1:0]];
         lane_vec_op_d = op_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         op_q          <= '0;
         tag_q         <= '0;
         vs1_q         <= '0;
         vs2_q         <= '0;
         res_q         <= '0;
         vl_q          <= '0;
         issue_idx_q   <= '0;
         collect_idx_q <= '0;
         lane_valid_q  <= 1'b0;
         lane_op1_q    <= '0;
         lane_op2_q    <= '0;
         lane_vec_op_q <= '0;
         resp_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         tag_q         <= tag_d;
         vs1_q         <= vs1_d;
         vs2_q         <= vs2_d;
         res_q         <= res_d;
         vl_q          <= vl_d;
         issue_idx_q   <= issue_idx_d;
         collect_idx_q <= collect_idx_d;
         lane_valid_q  <= lane_valid_d;
         lane_op1_q    <= lane_op1_d;
         lane_op2_q    <= lane_op2_d;
         lane_vec_op_q <= lane_vec_op_d;
         resp_valid_q  <= resp_valid_d;
      end
   end

   assign lane_valid  = lane_valid_q;
   assign lane_op1    = lane_op1_q;
   assign lane_op2    = lane_op2_q;
   assign lane_vec_op = lane_vec_op_q;
   assign resp_valid  = resp_valid_q;
   assign resp_data   = res_q;
   assign resp_tag    = tag_q;

endmodule

// File: doc/vector_elem_sequencer.md
VECTOR_ELEM_SEQUENCER -- requirements
Module: vector_elem_sequencer

Interface
REQ-001 SHALL have parameter ELEN, default 32, element width in bits.
REQ-002 SHALL have parameter VLEN, default 256, vector register width in bits; NE = VLEN/ELEN element slots (8 at defaults).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  vector op request present.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_op  input  4  element operation code (VEC_OP_* encoding).
REQ-008 SHALL have port req_vl  input  clog2(NE)+1  active element count.
REQ-009 SHALL have port req_vs1  input  VLEN  source vector 1; element i = bits [i*ELEN +: ELEN].
REQ-010 SHALL have port req_vs2  input  VLEN  source vector 2, same packing.
REQ-011 SHALL have port req_tag  input  6  destination/ROB tag, returned unchanged.
REQ-012 SHALL have port lane_op1, lane_op2  output  ELEN each  element operands to the lane.
REQ-013 SHALL have port lane_vec_op  output  4  operation code to the lane.
REQ-014 SHALL have port lane_valid  output  1  element issue strobe to the lane.
REQ-015 SHALL have port lane_result  input  ELEN  lane result.
REQ-016 SHALL have port lane_valid_out  input  1  lane result valid; arrives one cycle after lane_valid.
REQ-017 SHALL have port resp_valid  output  1  assembled result vector available.
REQ-018 SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-019 SHALL have port resp_data  output  VLEN  assembled result vector.
REQ-020 SHALL have port resp_tag  output  6  tag of the response.
REQ-021 SHALL have port flush  input  1  synchronous kill of the in-flight operation.

Function
REQ-022 SHALL implement states IDLE, ISSUE, DRAIN, RESP; req_ready = (state==IDLE) && !flush.
REQ-023 On accept (req_valid && req_ready) SHALL latch op, tag, vs1, vs2, and vl clamped to NE (vl>NE treated as NE); clear issue index, collect index and result buffer to zero.
REQ-024 Accept with clamped vl=0 SHALL go directly to RESP; otherwise to ISSUE.
REQ-025 In ISSUE SHALL drive lane_valid=1, lane_op1/lane_op2 = element[issue_idx] of vs1/vs2, lane_vec_op = latched op; issue_idx increments every ISSUE cycle, no stalls.
REQ-026 After issuing element vl-1 SHALL move to DRAIN; lane_valid=0 and lane operands/op = 0 in all states other than ISSUE.
REQ-027 Each cycle lane_valid_out=1 in ISSUE or DRAIN SHALL write lane_result into slot collect_idx and increment collect_idx; lane_valid_out in IDLE or RESP SHALL be ignored.
REQ-028 When the result for slot vl-1 is captured SHALL move to RESP; latency accept edge -> resp_valid high = vl+1 rising edges (1 for vl=0).
REQ-029 Tail slots (index >= vl) in resp_data SHALL be zero.
REQ-030 In RESP SHALL hold resp_valid=1 and resp_data/resp_tag stable until resp_ready=1, then return to IDLE; resp_valid=0 in all other states.
REQ-031 A new request SHALL NOT be accepted in the cycle a response is consumed (earliest acceptance one cycle later).
REQ-032 flush=1 SHALL return to IDLE at the next edge from any state, drop the response, and block acceptance that cycle; a late lane_valid_out after flush is ignored.

Reset
REQ-033 On rst_n=0 SHALL immediately enter IDLE with all counters, result buffer, resp_valid, resp_data, resp_tag, lane_valid, lane_op1, lane_op2, lane_vec_op = 0; req_ready = 1 after release; reset mid-operation discards the operation.

Verification
REQ-034 vl=4, ADD, vs1 elems {1,2,3,4}, vs2 elems {10,20,30,40}, 1-cycle lane model -> lane_valid high 4 cycles; resp_valid at edge 5; slots {11,22,33,44,0,0,0,0}; tag echoed.
REQ-035 vl=0 -> no lane_valid; resp_valid at edge 1 with resp_data=0.
REQ-036 vl=12 (>NE=8), XOR -> exactly 8 issues, all 8 slots filled, resp_valid at edge 9.
REQ-037 resp_ready held 0 for 3 cycles in RESP -> resp_valid/resp_data stable; req_ready=0 until the cycle after consume.
REQ-038 flush asserted during ISSUE after 2 issues -> IDLE next edge, no resp_valid, lane_valid=0; next request completes normally.
REQ-039 rst_n dropped mid-DRAIN -> all outputs 0 asynchronously; after release req_ready=1 and a fresh vl=1 SUB (5-7) returns 0xFFFFFFFE.
